// File: rtl/payment_pkg.sv
// rtl/payment_pkg.sv - shared state encodings and parameter defaults for the payment sequencer
package payment_pkg;

    localparam int unsigned DEF_MONEY_W   = 5;
    localparam int unsigned DEF_COIN_UNIT = 10;
    localparam int unsigned DEF_MAX_COIN  = 30;
    localparam int unsigned DEF_TIMEOUT   = 1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_REFUND = 3'd2,
        ST_CHANGE = 3'd3,
        ST_THANKS = 3'd4
    } state_t;

endpackage

// File: rtl/idle_timer.sv
// rtl/idle_timer.sv - saturating idle-cycle counter that flags the last cycle before timeout
module idle_timer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CAP  = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Count enabled idle cycles, saturating at TIMEOUT; restart clears.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            count <= '0;
        end else if (enable && count != CAP) begin
            count <= count + CW'(1);
        end
    end

    // High during the TIMEOUT-th consecutive idle cycle, so the owner acts on that edge.
    assign expired = enable && !restart && (count == LAST);

endmodule

// File: rtl/payment_sequencer.sv
// rtl/payment_sequencer.sv - coin accumulation, vend, change and refund sequencing
module payment_sequencer
    import payment_pkg::*;
#(
    parameter int unsigned MONEY_W   = DEF_MONEY_W,
    parameter int unsigned COIN_UNIT = DEF_COIN_UNIT,
    parameter int unsigned MAX_COIN  = DEF_MAX_COIN,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    input  logic [MONEY_W-1:0] price,
    input  logic               cancel,
    input  logic               change_done,
    output logic               coin_reject,
    output logic               change_start,
    output logic [MONEY_W-1:0] change_amount,
    output logic               vend,
    output logic [MONEY_W-1:0] total,
    output logic [2:0]         main_state
);

    state_t             state;
    logic [MONEY_W-1:0] price_q;
    logic [MONEY_W:0]   sum;
    logic [31:0]        coin_ext;
    logic               coin_ok;
    logic               expired;
    logic               payout_done;

    assign coin_ext = 32'(coin_value);
    assign coin_ok  = (coin_ext != 0) && ((coin_ext % COIN_UNIT) == 0) && (coin_ext <= MAX_COIN);
    // Extra carry bit detects a credit that would not fit in MONEY_W.
    assign sum      = {1'b0, total} + {1'b0, coin_value};
    // change_done is only honoured once change_start has already been seen by the dispenser.
    assign payout_done = (change_done && !change_start) || (change_amount == '0);
    assign main_state  = state;

    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clock   (clock),
        .reset   (reset),
        .restart (coin_valid || state != ST_ACCUM),
        .enable  (state == ST_ACCUM),
        .expired (expired)
    );

    // Transaction FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            price_q       <= '0;
            total         <= '0;
            change_amount <= '0;
            coin_reject   <= 1'b0;
            change_start  <= 1'b0;
            vend          <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            change_start <= 1'b0;
            vend         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (coin_valid) begin
                        if (coin_ok) begin
                            total   <= coin_value;
                            price_q <= price;
                            state   <= ST_ACCUM;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (cancel) begin
                        coin_reject   <= coin_valid;
                        change_amount <= total;
                        change_start  <= 1'b1;
                        state         <= ST_REFUND;
                    end else if (coin_valid) begin
                        if (!coin_ok) begin
                            coin_reject <= 1'b1;
                        end else if (sum[MONEY_W]) begin
                            coin_reject   <= 1'b1;
                            change_amount <= total;
                            change_start  <= 1'b1;
                            state         <= ST_REFUND;
                        end else begin
                            total <= sum[MONEY_W-1:0];
                        end
                    end else if (total >= price_q) begin
                        change_amount <= total - price_q;
                        change_start  <= (total != price_q);
                        vend          <= 1'b1;
                        state         <= ST_CHANGE;
                    end else if (expired) begin
                        change_amount <= total;
                        change_start  <= 1'b1;
                        state         <= ST_REFUND;
                    end
                end
                ST_REFUND, ST_CHANGE: begin
                    coin_reject <= coin_valid;
                    if (payout_done) begin
                        state <= ST_THANKS;
                    end
                end
                ST_THANKS: begin
                    coin_reject   <= coin_valid;
                    total         <= '0;
                    change_amount <= '0;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payment_sequencer.sv
// tb/tb_payment_sequencer.sv - directed self-checking bench for payment_sequencer
module tb_payment_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [4:0] coin_value;
    logic [4:0] price;
    logic       cancel;
    logic       change_done;
    logic       coin_reject;
    logic       change_start;
    logic [4:0] change_amount;
    logic       vend;
    logic [4:0] tot;
    logic [2:0] main_state;

    int n_total = 0;
    int n_bad   = 0;

    payment_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .price         (price),
        .cancel        (cancel),
        .change_done   (change_done),
        .coin_reject   (coin_reject),
        .change_start  (change_start),
        .change_amount (change_amount),
        .vend          (vend),
        .total         (tot),
        .main_state    (main_state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pulses(input string tag, input logic rej, input logic st, input logic vd);
        chk({tag, "_reject"}, 32'(coin_reject), 32'(rej));
        chk({tag, "_start"}, 32'(change_start), 32'(st));
        chk({tag, "_vend"}, 32'(vend), 32'(vd));
    endtask

    initial begin
        reset = 1'b1; coin_valid = 1'b0; coin_value = 5'd0; price = 5'd0;
        cancel = 1'b0; change_done = 1'b0;
        step(); step();
        chk("rst_state", 32'(main_state), 0);
        chk("rst_total", 32'(tot), 0);
        chk("rst_amount", 32'(change_amount), 0);
        chk_pulses("rst", 0, 0, 0);
        reset = 1'b0;

        // invalid coins in IDLE
        coin_valid = 1'b1; coin_value = 5'd15;
        step();
        chk("c15_reject", 32'(coin_reject), 1);
        chk("c15_state", 32'(main_state), 0);
        coin_value = 5'd0;
        step();
        chk("c0_reject", 32'(coin_reject), 1);
        chk("c0_state", 32'(main_state), 0);
        coin_valid = 1'b0;
        step();
        chk("c0_reject_clr", 32'(coin_reject), 0);

        // price 2, coins 20 + 10, change 28; later price change ignored
        price = 5'd2; coin_valid = 1'b1; coin_value = 5'd20;
        step();
        chk("p2_c20_state", 32'(main_state), 1);
        chk("p2_c20_total", 32'(tot), 20);
        price = 5'd9; coin_value = 5'd10;
        step();
        chk("p2_c10_state", 32'(main_state), 1);
        chk("p2_c10_total", 32'(tot), 30);
        chk_pulses("p2_c10", 0, 0, 0);
        coin_valid = 1'b0; change_done = 1'b1;
        step();
        chk("p2_chg_state", 32'(main_state), 3);
        chk("p2_chg_amount", 32'(change_amount), 28);
        chk_pulses("p2_chg", 0, 1, 1);
        step();
        chk("p2_early_done_state", 32'(main_state), 3);
        chk("p2_hold_amount", 32'(change_amount), 28);
        chk_pulses("p2_hold", 0, 0, 0);
        step();
        chk("p2_thanks", 32'(main_state), 4);
        change_done = 1'b0;
        step();
        chk("p2_idle", 32'(main_state), 0);
        chk("p2_idle_total", 32'(tot), 0);
        chk("p2_idle_amount", 32'(change_amount), 0);

        // exact payment, no change_start
        price = 5'd30; coin_valid = 1'b1; coin_value = 5'd30;
        step();
        chk("p30_accum", 32'(main_state), 1);
        coin_valid = 1'b0;
        step();
        chk("p30_chg_state", 32'(main_state), 3);
        chk("p30_chg_amount", 32'(change_amount), 0);
        chk_pulses("p30_chg", 0, 0, 1);
        step();
        chk("p30_thanks", 32'(main_state), 4);
        chk("p30_thanks_vend", 32'(vend), 0);
        step();
        chk("p30_idle", 32'(main_state), 0);

        // overflow coin forces refund of existing credit
        price = 5'd31; coin_valid = 1'b1; coin_value = 5'd20;
        step();
        chk("ovf_c1_total", 32'(tot), 20);
        step();
        chk("ovf_state", 32'(main_state), 2);
        chk("ovf_amount", 32'(change_amount), 20);
        chk("ovf_total", 32'(tot), 20);
        chk_pulses("ovf", 1, 1, 0);
        coin_value = 5'd10;
        step();
        chk("ref_coin_state", 32'(main_state), 2);
        chk_pulses("ref_coin", 1, 0, 0);
        coin_valid = 1'b0; change_done = 1'b1;
        step();
        chk("ovf_thanks", 32'(main_state), 4);
        change_done = 1'b0;
        step();
        chk("ovf_idle", 32'(main_state), 0);
        chk("ovf_idle_total", 32'(tot), 0);

        // cancel wins over a simultaneous coin
        price = 5'd25; coin_valid = 1'b1; coin_value = 5'd10;
        step();
        chk("can_accum", 32'(main_state), 1);
        cancel = 1'b1;
        step();
        chk("can_state", 32'(main_state), 2);
        chk("can_amount", 32'(change_amount), 10);
        chk("can_total", 32'(tot), 10);
        chk_pulses("can", 1, 1, 0);
        cancel = 1'b0; coin_valid = 1'b0; change_done = 1'b1;
        step();
        chk("can_early_done", 32'(main_state), 2);
        step();
        chk("can_thanks", 32'(main_state), 4);
        change_done = 1'b0;
        step();
        chk("can_idle", 32'(main_state), 0);

        // timeout after 1000 idle cycles in ACCUM
        coin_valid = 1'b1; coin_value = 5'd10;
        step();
        coin_valid = 1'b0;
        repeat (999) step();
        chk("to_before", 32'(main_state), 1);
        step();
        chk("to_state", 32'(main_state), 2);
        chk("to_amount", 32'(change_amount), 10);
        chk_pulses("to", 0, 1, 0);
        step();
        change_done = 1'b1;
        step();
        chk("to_thanks", 32'(main_state), 4);
        change_done = 1'b0;
        step();
        chk("to_idle", 32'(main_state), 0);

        // reset mid-transaction while waiting in CHANGE
        price = 5'd2; coin_valid = 1'b1; coin_value = 5'd10;
        step();
        coin_valid = 1'b0;
        step();
        chk("mr_chg_amount", 32'(change_amount), 8);
        step();
        chk("mr_wait", 32'(main_state), 3);
        reset = 1'b1;
        step();
        chk("mr_state", 32'(main_state), 0);
        chk("mr_total", 32'(tot), 0);
        chk("mr_amount", 32'(change_amount), 0);
        chk_pulses("mr", 0, 0, 0);
        reset = 1'b0;
        step();
        chk("mr_after", 32'(main_state), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
